imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Sequencer and arbiter for the byte-wide instruction memory. Turns a 32-bit fetch request from the IF stage into four sequential byte reads, assembles them big-endian, and returns the word through a valid/ready handshake. Shares the memory port with a byte-write program loader using alternating-priority arbitration. Sits between the IF stage/PC logic and the instruction memory array.

## Interface
- `ADDR_W`, 10: memory byte-address width (MEM_SIZE = 2**ADDR_W).
- `WORD_SIZE`, 32: fetch address and instruction width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `fetch_req` in 1: IF stage requests a word.
- `fetch_addr` in WORD_SIZE: byte address of the instruction MSB; low ADDR_W bits used.
- `fetch_ready` out 1: request accepted this cycle (combinational).
- `flush` in 1: cancel any in-flight or pending fetch.
- `inst_valid` out 1: `instruction` holds an assembled word.
- `inst_ready` in 1: IF stage consumes the word.
- `instruction` out WORD_SIZE: assembled word, byte at base in [31:24].
- `load_valid` in 1: loader wants a byte write.
- `load_addr` in ADDR_W: loader byte address.
- `load_data` in 8: loader byte.
- `load_ready` out 1: write performed this cycle (combinational).
- `mem_addr` out ADDR_W: memory byte address.
- `mem_we` out 1: memory write strobe.
- `mem_wdata` out 8: memory write byte.
- `mem_rdata` in 8: memory read byte, combinational from `mem_addr`.

## Operation
- States: IDLE, READ, RESP.
- IDLE: memory port free. The arbiter picks between `fetch_req` and `load_valid`.
  - If only one requests, it wins.
  - If both request, the winner is the side not granted last; `last_grant` updates on every grant.
- Fetch grant in IDLE:
  - `fetch_ready`=1.
  - Base latched as `fetch_addr[ADDR_W-1:0]`, byte counter `cnt`=0, next state READ.
- Load grant in IDLE:
  - `load_ready`=1, `mem_we`=1, `mem_addr`=`load_addr`, `mem_wdata`=`load_data`.
  - State stays IDLE, so back-to-back loads are possible.
- READ:
  - `mem_addr` = (base + cnt) mod 2**ADDR_W; wraps at the top of memory.
  - `mem_rdata` is captured into byte slot `cnt` (cnt 0 → [31:24]), then `cnt` increments.
  - After `cnt`=3 is captured, the next state is RESP.
  - No load is granted in READ; a fetch is never interrupted by the loader.
- RESP:
  - `inst_valid`=1 and `instruction` stays stable until `inst_ready`=1.
  - On `inst_ready`, the next state is IDLE. No new request is accepted in the same cycle.
- `flush`:
  - In READ or RESP: next state IDLE, no `inst_valid` is produced for the cancelled fetch, and `instruction` is left unchanged.
  - In IDLE: suppresses `fetch_ready` that cycle. A load may still be granted.
- No alignment check; any base address is legal.
- `mem_we`=0 and `mem_wdata`=0 whenever no load is granted. `mem_addr`=0 in IDLE with no grant.

## Timing
- Reset (`rst`=0, async):
  - Outputs: `fetch_ready`, `inst_valid`, `load_ready`, `mem_we` = 0; `instruction`=0; `mem_addr`=0; `mem_wdata`=0.
  - Internal: state IDLE, `cnt`=0, `last_grant`=FETCH, so the loader wins the first contested cycle.
- Reset mid-fetch aborts the fetch silently.
- Fetch accepted in cycle T: reads occur in T+1..T+4; `inst_valid` rises in T+5. Minimum fetch-to-fetch spacing is 6 cycles (`inst_ready` held high).
- Load latency: write occurs in the grant cycle; 1 cycle per byte.
- `flush` takes priority over `inst_ready` and over `fetch_req` in the same cycle.

## Configuration
- `IMEM_LOADER_EN` defined: loader port and arbitration as above.
- Not defined:
  - `load_*` inputs are ignored, `load_ready`=0, `mem_we`=0, `mem_wdata`=0.
  - Fetch is granted whenever requested in IDLE; `last_grant` logic is removed.
  - Port list is unchanged.

## Test plan
- Memory bytes 0..3 = 80 20 00 0A, fetch_addr=0 at T: `fetch_ready` at T, `inst_valid` at T+5 with 0x8020000A; with `inst_ready` low for 3 cycles, `instruction` is held stable.
- ADDR_W=10, fetch_addr=0x3FE, bytes at 0x3FE,0x3FF,0x000,0x001 = 11 22 33 44: `mem_addr` sequence 3FE,3FF,000,001 and `instruction`=0x11223344.
- `fetch_req` and `load_valid` held together from reset: grants go load, fetch (6 cycles), load, fetch…; the loaded byte is readable by the following fetch.
- `flush` at T+2 of a fetch: no `inst_valid`, IDLE at T+3, a new fetch is accepted at T+3 and its word is returned correctly.
- `rst` low during READ: all outputs 0 immediately; after release, the first contested cycle grants the loader.
- Build without `IMEM_LOADER_EN`, `load_valid`=1, load_data=0xFF: `mem_we` never asserts, `load_ready`=0, and fetches are unaffected.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between imem_fetch_ctrl and its neighbours: IF-stage fetch/response,
// program-loader byte writes and the byte-wide instruction memory port.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W    = 10,
  parameter int WORD_SIZE = 32
);
  logic                 fetch_req;
  logic [WORD_SIZE-1:0] fetch_addr;
  logic                 fetch_ready;
  logic                 flush;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [WORD_SIZE-1:0] instruction;
  logic                 load_valid;
  logic [ADDR_W-1:0]    load_addr;
  logic [7:0]           load_data;
  logic                 load_ready;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_we;
  logic [7:0]           mem_wdata;
  logic [7:0]           mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, flush, inst_ready,
           load_valid, load_addr, load_data, mem_rdata,
    output fetch_ready, inst_valid, instruction, load_ready,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, flush, inst_ready,
           load_valid, load_addr, load_data, mem_rdata,
    input  fetch_ready, inst_valid, instruction, load_ready,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer/arbiter: four big-endian byte reads per 32-bit fetch, shared port
// with a byte-write loader. Loader and arbitration enabled by macro IMEM_LOADER_EN.
module imem_fetch_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int WORD_SIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  imem_fetch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t               state, state_nx;
  logic [1:0]           cnt, cnt_nx;
  logic [ADDR_W-1:0]    base, base_nx;
  logic [23:0]          asm_q, asm_nx;
  logic [WORD_SIZE-1:0] instr_q, instr_nx;
  logic                 fetch_ok, grant_fetch;
`ifdef IMEM_LOADER_EN
  logic                 last_fetch, last_fetch_nx;
  logic                 grant_load;
  logic                 unused_in;
  assign unused_in = ^bus.fetch_addr[WORD_SIZE-1:ADDR_W];
`else
  logic                 unused_in;
  assign unused_in = ^{bus.fetch_addr[WORD_SIZE-1:ADDR_W], bus.load_valid,
                       bus.load_addr, bus.load_data};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      base    <= '0;
      asm_q   <= '0;
      instr_q <= '0;
`ifdef IMEM_LOADER_EN
      last_fetch <= 1'b1;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      base    <= base_nx;
      asm_q   <= asm_nx;
      instr_q <= instr_nx;
`ifdef IMEM_LOADER_EN
      last_fetch <= last_fetch_nx;
`endif
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    base_nx         = base;
    asm_nx          = asm_q;
    instr_nx        = instr_q;
    fetch_ok        = 1'b0;
    grant_fetch     = 1'b0;
    bus.fetch_ready = 1'b0;
    bus.inst_valid  = 1'b0;
    bus.load_ready  = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = '0;
    bus.instruction = instr_q;
`ifdef IMEM_LOADER_EN
    last_fetch_nx   = last_fetch;
    grant_load      = 1'b0;
`endif
    // Outputs are held inactive while reset is asserted, whatever the inputs do.
    if (rst) begin
      case (state)
        IDLE: begin
          fetch_ok = bus.fetch_req && !bus.flush;
`ifdef IMEM_LOADER_EN
          if (fetch_ok && bus.load_valid) begin
            grant_load  = last_fetch;
            grant_fetch = !last_fetch;
          end else begin
            grant_fetch = fetch_ok;
            grant_load  = bus.load_valid;
          end
          if (grant_load) begin
            bus.load_ready = 1'b1;
            bus.mem_we     = 1'b1;
            bus.mem_addr   = bus.load_addr;
            bus.mem_wdata  = bus.load_data;
            last_fetch_nx  = 1'b0;
          end
          if (grant_fetch) last_fetch_nx = 1'b1;
`else
          grant_fetch = fetch_ok;
`endif
          if (grant_fetch) begin
            bus.fetch_ready = 1'b1;
            base_nx         = bus.fetch_addr[ADDR_W-1:0];
            cnt_nx          = '0;
            state_nx        = READ;
          end
        end
        READ: begin
          bus.mem_addr = base + ADDR_W'(cnt);
          if (bus.flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            // Bytes 0..2 collect in a side buffer so a flushed fetch never disturbs
            // the last returned instruction; byte 3 completes the word.
            case (cnt)
              2'd0: asm_nx[23:16] = bus.mem_rdata;
              2'd1: asm_nx[15:8]  = bus.mem_rdata;
              2'd2: asm_nx[7:0]   = bus.mem_rdata;
              default: begin
                instr_nx = WORD_SIZE'({asm_q, bus.mem_rdata});
                state_nx = RESP;
              end
            endcase
            cnt_nx = cnt + 2'd1;
          end
        end
        RESP: begin
          if (bus.flush) begin
            state_nx = IDLE;
          end else begin
            bus.inst_valid = 1'b1;
            if (bus.inst_ready) state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule
